vgm_seq: RTL
============

# vgm_seq

VGM command sequencer for the MiSTer VGM player. It consumes the VGM command byte stream, with the header already stripped upstream, and decodes chip-write and wait commands. It drives the `jt10` CPU-side write port (`addr`, `din`, `wr_n`) with correctly spaced address and data cycles, and paces the stream against a 44.1 kHz sample strobe.

## Interface
- `WR_HOLD`, 2: number of `cen` pulses `fm_wr_n` is held low per write cycle (≥1).
- `WR_GAP`, 32: number of `cen` pulses `fm_wr_n` is held high after each write cycle before the next action (≥1).
- `clk` in 1: system clock; the same clock as `jt10`.
- `rst_n` in 1: asynchronous, active-low reset.
- `cen` in 1: `jt10` clock enable (`fm_cen`); used only for write-pulse timing.
- `smp_cen` in 1: one-`clk` strobe at 44100 Hz; the wait time base.
- `start` in 1: one-cycle pulse; starts playback from IDLE, DONE or ERR.
- `stop` in 1: synchronous abort to IDLE.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: sequencer accepts the byte this cycle.
- `fm_addr` out 2: to `jt10 addr`; bit 1 is the port (A1), bit 0 selects address (0) or data (1).
- `fm_din` out 8: to `jt10 din`.
- `fm_wr_n` out 1: to `jt10 wr_n`.
- `busy` out 1: high in every state except IDLE, DONE and ERR.
- `done` out 1: high in DONE (0x66 seen).
- `err` out 1: high in ERR.
- `err_cmd` out 8: the opcode that caused ERR.

## Operation
- States: IDLE, CMD, ARG1, ARG2, WRA, GAPA, WRD, GAPD, WAIT, DONE, ERR.
- `s_ready` is high only in CMD, ARG1 and ARG2. A byte transfers on a `clk` edge with `s_valid & s_ready`. A transfer advances the state on that edge.
- CMD decode:
  - 0x52 and 0x58 are port-0 writes: set `port`=0, go to ARG1.
  - 0x53 and 0x59 are port-1 writes: set `port`=1, go to ARG1.
  - 0x61: go to ARG1 to read a 16-bit little-endian wait count.
  - 0x62: load wait=735, go to WAIT.
  - 0x63: load wait=882, go to WAIT.
  - 0x70–0x7F: load wait=(low nibble)+1, go to WAIT.
  - 0x66: go to DONE.
  - Any other opcode: latch it into `err_cmd`, go to ERR.
- For a write command, ARG1 latches the register and ARG2 latches the value. Then:
  - WRA: `fm_addr`={port,0}, `fm_din`=register.
  - GAPA.
  - WRD: `fm_addr`={port,1}, `fm_din`=value.
  - GAPD, then CMD.
- For 0x61, ARG1 gives the low byte and ARG2 the high byte. If the count is 0, go straight to CMD; otherwise go to WAIT.
- WAIT: the 16-bit counter decrements on each `smp_cen`. When the counter reaches 0, go to CMD. A wait of n lasts exactly n `smp_cen` pulses.
- `start` in IDLE, DONE or ERR: clear `done` and `err`, go to CMD. `start` while `busy` is ignored.
- `stop` has priority over every transition. It forces IDLE and `fm_wr_n`=1 on the next edge, and clears the wait and pulse counters. `fm_addr` and `fm_din` hold their values.
- Reset values: state IDLE, `fm_wr_n`=1, `fm_addr`=0, `fm_din`=0, `s_ready`=0, `busy`=0, `done`=0, `err`=0, `err_cmd`=0. All counters are 0.

## Timing
- `fm_addr` and `fm_din` are registered. They change on the edge that enters WRA or WRD, in the same edge that drives `fm_wr_n` low. They stay stable through the following GAP state.
- In WRA and WRD, `fm_wr_n` stays low until `WR_HOLD` `cen` pulses have been counted. The edge that sees the last counted pulse sets `fm_wr_n`=1 and enters the GAP state.
- The GAP state lasts until `WR_GAP` `cen` pulses have been counted. A `cen` pulse on the entry edge is not counted.
- With `cen` stuck low, the sequencer stalls in WR or GAP indefinitely.
- `smp_cen` is ignored outside WAIT. A `smp_cen` on the edge that enters WAIT is not counted.
- `smp_cen` and `cen` are independent; simultaneous pulses need no special handling.
- Throughput: a write command costs 3 accepted bytes plus (2·`WR_HOLD` + 2·`WR_GAP`) `cen` pulses plus about 4 `clk`.
- Byte-acceptance latency: with `s_valid` held high, one byte transfers per `clk` across CMD, ARG1 and ARG2.

## Test plan
- Port-0 write: stream 0x58 0x28 0xF1 0x66 with `cen` every 6 `clk` and defaults.
  - `fm_wr_n` goes low for exactly 2 `cen` pulses with `fm_addr`=0 and `fm_din`=0x28.
  - Then high for 32 pulses, then low for 2 pulses with `fm_addr`=1 and `fm_din`=0xF1.
  - Then high for 32 pulses, then `done`=1 and `busy`=0.
- Port-1 write: stream 0x59 0x10 0x55 0x66. The two write cycles show `fm_addr`=2 then 3.
- Waits: stream 0x61 0x03 0x00, 0x70, 0x62, 0x61 0x00 0x00, 0x66.
  - CMD re-entries occur after 3, 1 and 735 `smp_cen` pulses.
  - The zero wait adds no `smp_cen` pulses.
  - `s_ready` stays low throughout each WAIT.
- Unknown opcode: stream 0x58 0x28 0xF1 0xB4. The write completes, then `err`=1, `err_cmd`=0xB4, `busy`=0 and `s_ready`=0. A following `start` clears `err`.
- Stall and backpressure:
  - Drop `s_valid` between ARG1 and ARG2 for 50 `clk`: no write is issued until 0xF1 arrives.
  - `start` pulsed while `busy` has no effect.
- Abort: assert `stop` while `fm_wr_n`=0 in WRD. On the next edge `fm_wr_n`=1, state is IDLE and `busy`=0; `done` and `err` stay 0.
- Reset mid-write: assert `rst_n`=0 asynchronously while `fm_wr_n`=0. `fm_wr_n` goes to 1 immediately, without waiting for a `clk` edge, and every output takes its reset value.

Source files
------------

// File: rtl/vgm_seq.sv
// VGM command sequencer: decodes chip-write and wait opcodes from the command stream,
// drives the jt10 CPU write port with spaced address/data cycles and paces waits on smp_cen.
module vgm_seq #(
    parameter int unsigned WR_HOLD = 2,
    parameter int unsigned WR_GAP  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       smp_cen,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [1:0] fm_addr,
    output logic [7:0] fm_din,
    output logic       fm_wr_n,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cmd
);

    localparam int unsigned PMAX = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
    localparam int unsigned PW   = $clog2(PMAX + 1);
    localparam int unsigned WW   = 16;

    typedef enum logic [3:0] {
        IDLE, CMD, ARG1, ARG2, WRA, GAPA, WRD, GAPD, WAIT, DONE, ERR
    } state_t;

    state_t          state;
    logic            port;
    logic            is_wait;
    logic [7:0]      reg_q;
    logic [7:0]      val_q;
    logic [WW-1:0]   wcnt;
    logic [PW-1:0]   pcnt;

    logic            xfer;
    logic            hold_last;
    logic            gap_last;

    assign xfer      = s_valid & s_ready;
    assign hold_last = (pcnt == PW'(WR_HOLD - 1));
    assign gap_last  = (pcnt == PW'(WR_GAP - 1));

    // State change plus the status outputs, all registered from the state being entered.
    task automatic enter(input state_t nxt);
        state   <= nxt;
        s_ready <= (nxt == CMD) || (nxt == ARG1) || (nxt == ARG2);
        busy    <= !((nxt == IDLE) || (nxt == DONE) || (nxt == ERR));
        done    <= (nxt == DONE);
        err     <= (nxt == ERR);
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            fm_wr_n <= 1'b1;
            fm_addr <= '0;
            fm_din  <= '0;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cmd <= '0;
            port    <= 1'b0;
            is_wait <= 1'b0;
            reg_q   <= '0;
            val_q   <= '0;
            wcnt    <= '0;
            pcnt    <= '0;
        end else if (stop) begin
            enter(IDLE);
            fm_wr_n <= 1'b1;
            wcnt    <= '0;
            pcnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) enter(CMD);
                end
                CMD: begin
                    if (xfer) begin
                        casez (s_data)
                            8'h52, 8'h58: begin port <= 1'b0; is_wait <= 1'b0; enter(ARG1); end
                            8'h53, 8'h59: begin port <= 1'b1; is_wait <= 1'b0; enter(ARG1); end
                            8'h61:        begin is_wait <= 1'b1; enter(ARG1); end
                            8'h62:        begin wcnt <= WW'(735); enter(WAIT); end
                            8'h63:        begin wcnt <= WW'(882); enter(WAIT); end
                            8'b0111_????: begin wcnt <= WW'(s_data[3:0]) + WW'(1); enter(WAIT); end
                            8'h66:        enter(DONE);
                            default:      begin err_cmd <= s_data; enter(ERR); end
                        endcase
                    end
                end
                ARG1: begin
                    if (xfer) begin
                        reg_q <= s_data;
                        enter(ARG2);
                    end
                end
                ARG2: begin
                    if (xfer) begin
                        if (is_wait) begin
                            // A zero wait count falls straight back to command fetch.
                            if ({s_data, reg_q} == '0) begin
                                enter(CMD);
                            end else begin
                                wcnt <= {s_data, reg_q};
                                enter(WAIT);
                            end
                        end else begin
                            val_q   <= s_data;
                            fm_addr <= {port, 1'b0};
                            fm_din  <= reg_q;
                            fm_wr_n <= 1'b0;
                            pcnt    <= '0;
                            enter(WRA);
                        end
                    end
                end
                WRA, WRD: begin
                    if (cen) begin
                        if (hold_last) begin
                            pcnt    <= '0;
                            fm_wr_n <= 1'b1;
                            enter((state == WRA) ? GAPA : GAPD);
                        end else begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                end
                GAPA, GAPD: begin
                    if (cen) begin
                        if (gap_last) begin
                            pcnt <= '0;
                            if (state == GAPA) begin
                                fm_addr <= {port, 1'b1};
                                fm_din  <= val_q;
                                fm_wr_n <= 1'b0;
                                enter(WRD);
                            end else begin
                                enter(CMD);
                            end
                        end else begin
                            pcnt <= pcnt + PW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (smp_cen) begin
                        if (wcnt == WW'(1)) begin
                            wcnt <= '0;
                            enter(CMD);
                        end else begin
                            wcnt <= wcnt - WW'(1);
                        end
                    end
                end
                default: enter(IDLE);
            endcase
        end
    end

endmodule
